// File: rtl/led_matrix_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_pkg
// Shared definitions for the 8x8 bi-colour LED matrix scanner.
//   MATRIX_ROWS / MATRIX_COLS : default matrix geometry
//   frame_plane_t             : one colour plane, bit r*COLS+c = row r, col c
//   pix_idx(row, col)         : flat bit index of a pixel inside a plane
// -----------------------------------------------------------------------------
package led_matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;

    typedef logic [MATRIX_ROWS*MATRIX_COLS-1:0] frame_plane_t;

    function automatic int unsigned pix_idx(input int unsigned row, input int unsigned col);
        return row * MATRIX_COLS + col;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running phase counter that paces the row dwell.
//   CLK     : system clock
//   RESET_N : synchronous, active-low reset
//   cnt     : phase counter, counts 0..DIV-1 and wraps
//   tick    : high for the single cycle in which cnt == DIV-1
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DIV = 5000,
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          CLK,
    input  logic          RESET_N,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    assign tick = (cnt == CW'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
// Double-buffered row scanner for an 8x8 bi-colour LED matrix. A frame offered
// by the game logic lands in a pending buffer and is promoted to the active
// buffer only at a frame boundary, so a half-updated board is never shown.
// Each row dwell starts with a short all-rows-off window against ghosting.
//   CLK         : system clock
//   RESET_N     : synchronous, active-low reset
//   frame_r/g   : red / green pixel planes, bit r*COLS+c = row r, column c
//   frame_valid : producer offers frame_r/frame_g
//   frame_ready : pending buffer is free (low while in reset)
//   row_sel     : row drivers, active-low, at most one bit low
//   col_r/col_g : column drivers for the selected row, active-high
//   frame_start : one-cycle pulse as the row-0 dwell begins
// -----------------------------------------------------------------------------
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = MATRIX_ROWS,
    parameter int COLS         = MATRIX_COLS,
    parameter int SCAN_DIV     = 5000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [ROWS*COLS-1:0] frame_r,
    input  logic [ROWS*COLS-1:0] frame_g,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_r,
    output logic [COLS-1:0]      col_g,
    output logic                 frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = ROWS * COLS;

    logic [CW-1:0]   cnt;
    logic            tick;
    logic [RW-1:0]   row;
    logic            last_row;
    logic            boundary;
    logic            accept;

    logic [PW-1:0]   act_r;
    logic [PW-1:0]   act_g;
    logic [PW-1:0]   pend_r;
    logic [PW-1:0]   pend_g;
    logic            pend_full;

    logic [COLS-1:0] act_r_rows [ROWS];
    logic [COLS-1:0] act_g_rows [ROWS];

    logic [ROWS-1:0] row_sel_d;
    logic [COLS-1:0] col_r_d;
    logic [COLS-1:0] col_g_d;
    logic            frame_start_d;

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .cnt     (cnt),
        .tick    (tick)
    );

    assign last_row    = (row == RW'(ROWS - 1));
    assign boundary    = tick && last_row;
    assign frame_ready = RESET_N && !pend_full;
    // Accept needs an empty pending buffer and a swap needs a full one, so the
    // two never collide on the same edge.
    assign accept      = frame_valid && frame_ready;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            row <= '0;
        end else if (tick) begin
            row <= last_row ? '0 : row + 1'b1;
        end
    end

    // NOTE: the frame buffers are ordinary flops, not a RAM, so they take the
    // reset too; this guarantees a dark display until a new frame is loaded.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            act_r     <= '0;
            act_g     <= '0;
            pend_r    <= '0;
            pend_g    <= '0;
            pend_full <= 1'b0;
        end else begin
            if (boundary && pend_full) begin
                act_r     <= pend_r;
                act_g     <= pend_g;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend_r    <= frame_r;
                pend_g    <= frame_g;
                pend_full <= 1'b1;
            end
        end
    end

    // Row-major view of the active planes so the current row is a plain index.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            act_r_rows[i] = act_r[i*COLS +: COLS];
            act_g_rows[i] = act_g[i*COLS +: COLS];
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        row_sel_d     = '1;
        col_r_d       = '0;
        col_g_d       = '0;
        frame_start_d = (row == '0) && (cnt == '0);
        if (cnt >= CW'(BLANK_CYCLES)) begin
            row_sel_d = ~(ROWS'(1) << row);
            col_r_d   = act_r_rows[row];
            col_g_d   = act_g_rows[row];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            row_sel     <= '1;
            col_r       <= '0;
            col_g       <= '0;
            frame_start <= 1'b0;
        end else begin
            row_sel     <= row_sel_d;
            col_r       <= col_r_d;
            col_g       <= col_g_d;
            frame_start <= frame_start_d;
        end
    end

endmodule
